// File: rtl/mem_port_arbiter.sv
// Shares the MMU's single port A between instruction fetch and load/store.
// Round-robin grant, one transaction in flight, busy-timeout abort.
module mem_port_arbiter #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int TIMEOUT       = 255,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_ack,
    output logic [BUS_WIDTH-1:0]     if_rdata,
    output logic                     if_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [BUS_WIDTH-1:0]     d_wdata,
    output logic                     d_ack,
    output logic [BUS_WIDTH-1:0]     d_rdata,
    output logic                     d_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]     mem_wdata,
    input  logic                     mem_busy,
    input  logic [BUS_WIDTH-1:0]     mem_rdata,
    output logic                     grant_d
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

    state_t                   state_q, state_d;
    logic                     owner_q, owner_d;       // 0 = fetch, 1 = load/store
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     quiet_q, quiet_d;       // one idle busy sample already seen
    logic                     err_q, err_d;
    logic [BUS_WIDTH-1:0]     if_rdata_q, if_rdata_d;
    logic [BUS_WIDTH-1:0]     d_rdata_q, d_rdata_d;
    logic                     pick;
    logic                     done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            quiet_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            quiet_q    <= quiet_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        quiet_d    = quiet_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        pick       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    // On a tie the requester that did not own the last grant wins
                    pick    = (if_req && d_req) ? ~owner_q : d_req;
                    owner_d = pick;
                    we_d    = pick & d_we;
                    addr_d  = pick ? d_addr : if_addr;
                    wdata_d = pick ? d_wdata : '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                quiet_d = 1'b0;
                err_d   = 1'b0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                // A single-cycle MMU never shows busy: two quiet samples mean done
                done = !mem_busy && ((state_q == S_WAIT_DONE) || quiet_q);
                if (done || (cnt_q == TIMEOUT_CNT)) begin
                    err_d = !done;
                    if (owner_q) begin
                        d_rdata_d = done ? mem_rdata : '0;
                    end else begin
                        if_rdata_d = done ? mem_rdata : '0;
                    end
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    state_d = S_RESP;
                end else begin
                    quiet_d = !mem_busy;
                    if (mem_busy) begin
                        state_d = S_WAIT_DONE;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = (state_q == S_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == S_RESP) && !owner_q;
    assign d_ack     = (state_q == S_RESP) && owner_q;
    assign if_err    = if_ack && err_q;
    assign d_err     = d_ack && err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign grant_d   = owner_q;

endmodule
